// File: rtl/pc_fetch_pipe.sv
// Fetch front end: PC register, next-PC/branch-target selection and the IF/ID register.
// `define FETCH_SQUASH_EN turns a taken branch's fall-through fetch into a bubble, removing the delay slot.
module pc_fetch_pipe #(
  parameter int                ADDR_W     = 64,
  parameter int                INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic               br_taken,
  input  logic               br_uncond,
  input  logic               br_reg,
  input  logic [18:0]        imm19,
  input  logic [25:0]        imm26,
  input  logic [ADDR_W-1:0]  br_reg_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic               br_eff;
  logic               squash;
  logic [ADDR_W-1:0]  imm_sext;
  logic [ADDR_W-1:0]  rel_target;
  logic [ADDR_W-1:0]  br_target;
  logic [ADDR_W-1:0]  next_pc;

  // A bubble in decode carries no branch, so its branch inputs are meaningless.
  assign br_eff = br_taken & instr_valid_q;

`ifdef FETCH_SQUASH_EN
  assign squash = br_eff;
`else
  assign squash = 1'b0;
`endif

  always_comb begin
    if (br_uncond) begin
      imm_sext = {{(ADDR_W-26){imm26[25]}}, imm26};
    end else begin
      imm_sext = {{(ADDR_W-19){imm19[18]}}, imm19};
    end
  end

  assign rel_target = instr_pc_q + (imm_sext << 2);
  assign br_target  = br_reg ? br_reg_addr : rel_target;
  assign next_pc    = br_eff ? br_target : pc_q + ADDR_W'(4);

  always_comb begin
    pc_d          = stall ? pc_q : next_pc;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;
    // Flush wins over stall for IF/ID only; the PC above still honours stall.
    if (flush || (!stall && squash)) begin
      instr_d       = '0;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b0;
    end else if (!stall) begin
      instr_d       = imem_rdata;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_ADDR;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_pipe.sv
// Directed bench for pc_fetch_pipe: a spec-level model compared every cycle plus literal pins.
module tb_pc_fetch_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, flush, br_taken, br_uncond, br_reg;
  logic [18:0] imm19;
  logic [25:0] imm26;
  logic [63:0] br_reg_addr;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic [3:0]  fetch_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

`ifdef FETCH_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  pc_fetch_pipe #(.ADDR_W(64), .INSTR_W(32), .RESET_ADDR(64'h0), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .br_taken(br_taken), .br_uncond(br_uncond),
    .br_reg(br_reg), .imm19(imm19), .imm26(imm26), .br_reg_addr(br_reg_addr),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Spec-level model: fetch address, decode slot and counter as plain variables.
  logic [63:0] m_pc, m_ipc, m_tgt, m_nxt;
  logic [31:0] m_instr;
  logic        m_valid, m_br;
  logic [3:0]  m_cnt;
  longint      m_off;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc = 64'h0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_cnt = '0;
    end else begin
      m_br  = br_taken && m_valid;
      m_off = br_uncond ? longint'($signed(imm26)) : longint'($signed(imm19));
      m_tgt = br_reg ? br_reg_addr : m_ipc + 64'(m_off * 4);
      m_nxt = m_br ? m_tgt : m_pc + 64'd4;
      if (flush || (!stall && SQ && m_br)) begin
        m_instr = '0; m_ipc = m_pc; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = mem(m_pc); m_ipc = m_pc; m_valid = 1'b1; m_cnt = m_cnt + 4'd1;
      end
      if (!stall) m_pc = m_nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_imem_addr", imem_addr, m_pc);
      chk("cmp_instr", 64'(instr), 64'(m_instr));
      chk("cmp_instr_pc", instr_pc, m_ipc);
      chk("cmp_instr_valid", 64'(instr_valid), 64'(m_valid));
      chk("cmp_fetch_count", 64'(fetch_count), 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_br();
    br_taken = 1'b0; br_uncond = 1'b0; br_reg = 1'b0;
    imm19 = '0; imm26 = '0; br_reg_addr = '0;
  endtask

  logic [63:0] s_addr, s_ipc;
  logic [31:0] s_instr;
  logic [3:0]  s_cnt;

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    clr_br();
    step(); step();
    chk_en = 1'b1;
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_cnt", 64'(fetch_count), 64'h0);
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_ipc", instr_pc, 64'h0);
    reset = 1'b1;
    chk("first_bubble", 64'(instr_valid), 64'h0);

    step();
    chk("seq0_ipc", instr_pc, 64'h0);
    chk("seq0_valid", 64'(instr_valid), 64'h1);
    chk("seq0_instr", 64'(instr), 64'h5A5A_0000);
    chk("seq0_addr", imem_addr, 64'h4);
    chk("seq0_cnt", 64'(fetch_count), 64'h1);
    step();
    chk("seq1_ipc", instr_pc, 64'h4);
    chk("seq1_addr", imem_addr, 64'h8);
    chk("seq1_cnt", 64'(fetch_count), 64'h2);

    // Conditional branch at decode pc 4, imm19=2 -> 12.
    br_taken = 1'b1; imm19 = 19'd2;
    step();
    chk("bcond_addr", imem_addr, 64'hC);
    chk("bcond_slot_ipc", instr_pc, 64'h8);
    chk("bcond_slot_valid", 64'(instr_valid), SQ ? 64'h0 : 64'h1);
    chk("bcond_slot_cnt", 64'(fetch_count), SQ ? 64'h2 : 64'h3);
    clr_br();
    step();
    chk("bcond_tgt_ipc", instr_pc, 64'hC);
    chk("bcond_tgt_valid", 64'(instr_valid), 64'h1);

    // Unconditional imm26=-1 at decode pc 16 -> 12.
    step();
    br_taken = 1'b1; br_uncond = 1'b1; imm26 = 26'h3FF_FFFF;
    step();
    chk("buncond_addr", imem_addr, 64'hC);
    clr_br();
    step();
    chk("buncond_ipc", instr_pc, 64'hC);

    br_taken = 1'b1; br_reg = 1'b1; br_reg_addr = 64'h100;
    step();
    chk("breg_addr", imem_addr, 64'h100);
    clr_br();
    step();
    chk("breg_next", imem_addr, 64'h104);

    br_taken = 1'b1; br_reg = 1'b1; br_reg_addr = 64'h8;
    step();
    clr_br();
    step(); step(); step();
    chk("pre_stall_addr", imem_addr, 64'h14);
    chk("pre_stall_ipc", instr_pc, 64'h10);

    // Stall with a pending branch (16 + 4*4 = 32) for 3 cycles.
    stall = 1'b1; br_taken = 1'b1; imm19 = 19'd4;
    s_addr = imem_addr; s_instr = instr; s_ipc = instr_pc; s_cnt = fetch_count;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", imem_addr, s_addr);
      chk("stall_instr", 64'(instr), 64'(s_instr));
      chk("stall_ipc", instr_pc, s_ipc);
      chk("stall_cnt", 64'(fetch_count), 64'(s_cnt));
    end
    stall = 1'b0;
    step();
    chk("stall_redirect", imem_addr, 64'h20);
    chk("stall_slot_ipc", instr_pc, 64'h14);
    clr_br();
    step();

    s_cnt = fetch_count;
    flush = 1'b1;
    step();
    chk("flush_valid", 64'(instr_valid), 64'h0);
    chk("flush_instr", 64'(instr), 64'h0);
    chk("flush_cnt", 64'(fetch_count), 64'(s_cnt));
    chk("flush_addr", imem_addr, 64'h28);
    flush = 1'b0; br_taken = 1'b1; imm19 = 19'd100;
    step();
    chk("bubble_br_ignored", imem_addr, 64'h2C);
    // Flush with a live branch: 40 - 8 = 32, decode becomes a bubble.
    flush = 1'b1; br_taken = 1'b1; imm19 = 19'h7FFFE;
    step();
    chk("flush_br_addr", imem_addr, 64'h20);
    chk("flush_br_valid", 64'(instr_valid), 64'h0);
    flush = 1'b0;
    clr_br();
    step();

    reset = 1'b0;
    step();
    chk("midrst_addr", imem_addr, 64'h0);
    chk("midrst_valid", 64'(instr_valid), 64'h0);
    chk("midrst_cnt", 64'(fetch_count), 64'h0);
    reset = 1'b1;
    step();
    br_taken = 1'b1; br_reg = 1'b1; br_reg_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    chk("wrap_pre", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    clr_br();
    step();
    chk("wrap_post", imem_addr, 64'h0);
    step(); step();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
